// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared widths and constants for the SPI mode-0 target.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);
    localparam int SPI_MODE   = 0;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
    typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchroniser for one async pin with level output
//               and single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_target
// Description : SPI mode-0 target; oversampled MOSI deserialiser and MISO
//               serialiser with optional echo of the last received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter bit                    ECHO        = 1'b1,
    parameter logic [SPI_BYTE_W-1:0] TX_RESET    = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_pending,
    output logic                  busy
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_mosi_lvl, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk_i),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_async(ss_n_i),
        .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(mosi_i),
        .o_level(w_mosi_lvl), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    spi_cnt_t  r_bitcnt;
    spi_byte_t r_rx_shift;
    spi_byte_t r_rx_data;
    logic      r_rx_valid;
    spi_byte_t r_tx_shift;
    spi_byte_t r_tx_buf;
    logic      r_tx_pending;
    logic      r_reload;
    logic      r_skip_fall;

    logic      w_busy;
    logic      w_rx_step;
    logic      w_byte_done;
    logic      w_tx_fall;
    logic      w_shifter_load;
    spi_byte_t w_rx_next;

    assign w_busy         = ~w_ss_lvl;
    assign w_rx_step      = w_sclk_rise & w_busy;
    assign w_byte_done    = w_rx_step & (r_bitcnt == SPI_CNT_W'(SPI_BYTE_W - 1));
    assign w_rx_next      = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi_lvl};
    assign w_tx_fall      = w_sclk_fall & w_busy;
    assign w_shifter_load = w_ss_fall | (w_tx_fall & r_reload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_reload   <= 1'b0;
        end else begin
            r_rx_valid <= w_byte_done;
            if (w_byte_done) begin
                r_rx_data <= w_rx_next;
            end
            if (w_ss_rise) begin
                r_bitcnt <= '0;
                r_reload <= 1'b0;
            end else if (w_rx_step) begin
                r_rx_shift <= w_rx_next;
                r_bitcnt   <= r_bitcnt + SPI_CNT_W'(1);
                if (w_byte_done) begin
                    r_reload <= 1'b1;
                end
            end else if (w_tx_fall) begin
                r_reload <= 1'b0;
            end
        end
    end

    // A select that falls while SCLK is high leaves one stray falling edge to swallow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift  <= '0;
            r_skip_fall <= 1'b0;
        end else if (w_ss_rise) begin
            r_tx_shift  <= '0;
            r_skip_fall <= 1'b0;
        end else if (w_ss_fall) begin
            r_tx_shift  <= r_tx_buf;
            r_skip_fall <= w_sclk_lvl;
        end else if (w_tx_fall) begin
            r_skip_fall <= 1'b0;
            if (r_reload) begin
                r_tx_shift <= r_tx_buf;
            end else if (!r_skip_fall) begin
                r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_buf     <= TX_RESET;
            r_tx_pending <= 1'b0;
        end else begin
            if (tx_load) begin
                r_tx_buf <= tx_data;
            end else if (ECHO && w_byte_done && !r_tx_pending) begin
                r_tx_buf <= w_rx_next;
            end
            // A new load wins over a coincident shifter load so the fresh byte stays pending.
            if (tx_load) begin
                r_tx_pending <= 1'b1;
            end else if (w_shifter_load) begin
                r_tx_pending <= 1'b0;
            end
        end
    end

    assign busy       = w_busy;
    assign miso_oe_o  = w_busy;
    assign miso_o     = w_busy & r_tx_shift[SPI_BYTE_W-1];
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_pending = r_tx_pending;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_target
// Description : Directed scoreboard bench for spi_target (RX bytes and MISO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_i, ss_n_i, mosi_i;
    logic       miso_o, miso_oe_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    spi_target #(.SYNC_STAGES(2), .ECHO(1'b1), .TX_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_pending(tx_pending), .busy(busy)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // RX scoreboard: one pop per rx_valid strobe.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %02h expected no strobe", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_rx.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h expected %02h", rx_data, e);
                end
            end
        end
    end

    // MISO monitor: initiator-side capture on SCLK rise, partial bytes dropped at SS_N rise.
    logic [7:0] mon_byte = 8'h00;
    int         mon_cnt  = 0;
    always @(posedge sclk_i or posedge ss_n_i) begin
        if (ss_n_i) begin
            mon_cnt = 0;
        end else begin
            mon_byte = {mon_byte[6:0], miso_o};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                checks++;
                if (exp_miso.size() == 0) begin
                    errors++;
                    $display("FAIL miso_unexpected: got %02h expected no byte", mon_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_miso.pop_front();
                    if (mon_byte !== e) begin
                        errors++;
                        $display("FAIL miso_byte: got %02h expected %02h", mon_byte, e);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic win_open();
        ss_n_i = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic win_close();
        wait_clk(HALF);
        ss_n_i = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Drives nbits MSB-first; optional tx_load lands in the cycle the last rise is acted on.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit do_load,
                             input logic [7:0] ld);
        for (int i = 0; i < nbits; i++) begin
            mosi_i = b[7-i];
            wait_clk(HALF);
            sclk_i = 1'b1;
            if (do_load && i == nbits - 1) begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                tx_data = ld;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                chk("coincident_pending", 8'(tx_pending), 8'h01);
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
            sclk_i = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] miso_exp);
        exp_rx.push_back(b);
        exp_miso.push_back(miso_exp);
        send_bits(b, 8, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        wait_clk(3);
        chk("rst_miso",       8'(miso_o),     8'h00);
        chk("rst_miso_oe",    8'(miso_oe_o),  8'h00);
        chk("rst_rx_data",    rx_data,        8'h00);
        chk("rst_rx_valid",   8'(rx_valid),   8'h00);
        chk("rst_tx_pending", 8'(tx_pending), 8'h00);
        chk("rst_busy",       8'(busy),       8'h00);
        rst_n = 1'b1;
        wait_clk(4);

        // Write 0x12, then read it back through the echo path.
        win_open(); xfer(8'h12, 8'h00); win_close();
        win_open(); xfer(8'h00, 8'h12); win_close();

        // Explicit reply byte loaded while idle.
        tx_data = 8'hA5; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        chk("load_pending", 8'(tx_pending), 8'h01);
        win_open();
        chk("ssfall_pending", 8'(tx_pending), 8'h00);
        chk("busy_high",      8'(busy),       8'h01);
        chk("miso_oe_high",   8'(miso_oe_o),  8'h01);
        xfer(8'h3C, 8'hA5);
        win_close();

        // Back-to-back bytes under one select.
        win_open(); xfer(8'h81, 8'h3C); xfer(8'h7E, 8'h81); win_close();

        // Partial byte aborted, then a clean byte.
        win_open(); send_bits(8'hFF, 5, 1'b0, 8'h00); win_close();
        win_open(); xfer(8'h55, 8'h7E); win_close();

        // Select falls while SCLK is high.
        sclk_i = 1'b1;
        wait_clk(HALF);
        ss_n_i = 1'b0;
        wait_clk(HALF);
        sclk_i = 1'b0;
        wait_clk(HALF);
        xfer(8'hC3, 8'h55);
        win_close();

        // Reset mid-byte.
        win_open(); send_bits(8'hAA, 4, 1'b0, 8'h00);
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(1);
        chk("midrst_miso_oe",  8'(miso_oe_o),  8'h00);
        chk("midrst_miso",     8'(miso_o),     8'h00);
        chk("midrst_rx_data",  rx_data,        8'h00);
        chk("midrst_busy",     8'(busy),       8'h00);
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(HALF);
        ss_n_i = 1'b1;
        wait_clk(2 * HALF);
        win_open(); xfer(8'h96, 8'h00); win_close();

        // tx_load coincident with byte completion: load beats echo.
        win_open();
        exp_rx.push_back(8'h0F);
        exp_miso.push_back(8'h96);
        send_bits(8'h0F, 8, 1'b1, 8'hE7);
        wait_clk(HALF);
        chk("reload_pending", 8'(tx_pending), 8'h00);
        win_close();
        win_open(); xfer(8'h00, 8'hE7); win_close();

        wait_clk(10);
        chk("final_rx_data", rx_data, 8'h00);
        checks++;
        if (exp_rx.size() != 0) begin
            errors++;
            $display("FAIL rx_leftover: got %0d expected 0", exp_rx.size());
        end
        checks++;
        if (exp_miso.size() != 0) begin
            errors++;
            $display("FAIL miso_leftover: got %0d expected 0", exp_miso.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
